count_req_arbiter: RTL and testbench

//   Shares one saturating event counter between NREQ requesters.
//   A round-robin arbiter grants at most one increment per cycle and stops granting when count reaches LIMIT.
//   It raises a delayed 'valid' flag: a grant occurred and the count is still below LIMIT.

---
 rtl/count_req_arbiter.sv | 84 ++++++++
 tb/tb_count_req_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/count_req_arbiter.sv
// count_req_arbiter: round-robin arbiter feeding a shared saturating counter with delayed valid flag.
// Optional COUNT_ARB_LOCK_EN adds a lock input that lets the last winner keep the grant.
module count_req_arbiter #(
    parameter int NREQ  = 4,
    parameter int CW    = 4,
    parameter int LIMIT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
`ifdef COUNT_ARB_LOCK_EN
    input  logic [NREQ-1:0] lock,
`endif
    input  logic            clr,
    output logic [NREQ-1:0] gnt,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            valid
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] LIM = CW'(LIMIT);
    typedef enum logic [1:0] {IDLE, GRANT, FULL} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n, rr_win, win, idx;
    logic [NREQ-1:0] gnt_n;
    logic [CW-1:0] count_n;
    logic gnt_any_d, hold;
    // Scan downward so the lowest offset from the pointer is the last (winning) assignment
    always_comb begin
        rr_win = ptr;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) rr_win = idx;
        end
    end
`ifdef COUNT_ARB_LOCK_EN
    logic [PW-1:0] last;
    assign hold = (state == GRANT) && req[last] && lock[last];
    assign win = hold ? last : rr_win;
    always_ff @(posedge clk) begin
        if (!rst) last <= '0;
        else if (|gnt_n) last <= win;
    end
`else
    assign hold = 1'b0;
    assign win = rr_win;
`endif
    always_comb begin
        state_n = state;
        gnt_n = '0;
        count_n = count;
        ptr_n = ptr;
        if (clr) begin
            state_n = IDLE;
            count_n = '0;
        end else if (|req && count < LIM) begin
            gnt_n[win] = 1'b1;
            count_n = count + CW'(1);
            ptr_n = hold ? ptr : ((int'(win) == NREQ - 1) ? '0 : win + PW'(1));
            state_n = (count_n == LIM) ? FULL : GRANT;
        end else begin
            state_n = (state == FULL) ? FULL : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr <= '0;
            gnt <= '0;
            count <= '0;
            gnt_any_d <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            gnt <= gnt_n;
            count <= count_n;
            gnt_any_d <= |gnt;
            valid <= gnt_any_d && (count < LIM);
        end
    end
    assign full = (state == FULL);
endmodule

// File: tb/tb_count_req_arbiter.sv
// tb_count_req_arbiter: directed and random checks of count_req_arbiter against an integer model.
module tb_count_req_arbiter;
    localparam int NREQ = 4, CW = 4, LIMIT = 5;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
    logic [NREQ-1:0] req = '0, gnt;
    logic [CW-1:0] count;
    logic full, valid;
    int errors = 0, checks = 0;
    int m_cnt = 0, m_ptr = 0, m_gnt = 0, m_gad = 0, m_valid = 0;

    always #5 clk = ~clk;

    count_req_arbiter #(.NREQ(NREQ), .CW(CW), .LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .req(req),
`ifdef COUNT_ARB_LOCK_EN
        .lock('0),
`endif
        .clr(clr), .gnt(gnt), .count(count), .full(full), .valid(valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model follows the behavioural rules with plain integers: one edge per call
    task automatic model_edge(input logic r, input int rq, input logic c);
        int w;
        if (!r) begin
            m_cnt = 0; m_ptr = 0; m_gnt = 0; m_gad = 0; m_valid = 0;
            return;
        end
        m_valid = (m_gad != 0) && (m_cnt < LIMIT);
        m_gad = (m_gnt != 0);
        if (c) begin
            m_cnt = 0; m_gnt = 0;
        end else if (rq != 0 && m_cnt < LIMIT) begin
            w = -1;
            for (int k = 0; k < NREQ && w < 0; k++)
                if (rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            m_gnt = 1 << w;
            m_cnt++;
            m_ptr = (w + 1) % NREQ;
        end else begin
            m_gnt = 0;
        end
    endtask

    task automatic step(input logic r, input int rq, input logic c);
        rst = r; req = rq[NREQ-1:0]; clr = c;
        @(posedge clk);
        model_edge(r, rq, c);
        #1;
        chk("gnt", int'(gnt), m_gnt);
        chk("count", int'(count), m_cnt);
        chk("full", int'(full), int'(m_cnt == LIMIT));
        chk("valid", int'(valid), m_valid);
    endtask

    initial begin
        int exp_g[5] = '{1, 2, 4, 8, 1};
        // reset holds everything at zero despite requests
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'hF, 1'b0);
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_valid", int'(valid), 0);
        end
        // round-robin sweep until saturation
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("rr_gnt", int'(gnt), exp_g[i]);
            chk("rr_count", int'(count), i + 1);
        end
        chk("sat_full", int'(full), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("sat_gnt", int'(gnt), 0);
            chk("sat_count", int'(count), LIMIT);
        end
        // single request pulse and delayed valid
        step(1'b0, 0, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        chk("pulse_gnt", int'(gnt), 4);
        chk("pulse_count", int'(count), 1);
        step(1'b1, 0, 1'b0);
        chk("pulse_valid0", int'(valid), 0);
        step(1'b1, 0, 1'b0);
        chk("pulse_valid1", int'(valid), 1);
        step(1'b1, 0, 1'b0);
        chk("pulse_valid2", int'(valid), 0);
        // clear beats a simultaneous request
        step(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b0);
        chk("pre_clr_count", int'(count), 3);
        step(1'b1, 4'h1, 1'b1);
        chk("clr_count", int'(count), 0);
        chk("clr_gnt", int'(gnt), 0);
        chk("clr_full", int'(full), 0);
        step(1'b1, 4'h1, 1'b0);
        chk("post_clr_gnt", int'(gnt), 1);
        chk("post_clr_count", int'(count), 1);
        // reset mid-run with pointer at 2 restarts priority at req[0]
        step(1'b0, 0, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        chk("mid_count", int'(count), 4);
        step(1'b0, 4'hF, 1'b0);
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_count", int'(count), 0);
        step(1'b1, 4'hF, 1'b0);
        chk("mid_rel_gnt", int'(gnt), 1);
        // random traffic against the model
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) != 0), $urandom_range(0, 15), ($urandom_range(0, 9) == 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
